// File: rtl/sd_read_scheduler.sv
// Shares one SPI-mode SD engine between NUM_REQ block-read requesters: arbitration, CMD17 argument,
// R1/data sequencing with timeout and bounded retry. Define SD_SCHED_RR_EN for round-robin arbitration.
module sd_read_scheduler #(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 200000,
    parameter int MAX_RETRY   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init_done,
    input  logic                  sdsc,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_sector,
    output logic [NUM_REQ-1:0]    req_grant,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [NUM_REQ-1:0]    req_error,
    output logic                  rd_valid,
    output logic [7:0]            rd_data,
    output logic                  rd_last,
    output logic                  eng_cmd_valid,
    output logic [5:0]            eng_cmd_index,
    output logic [31:0]           eng_cmd_arg,
    input  logic                  eng_cmd_ready,
    input  logic                  eng_r1_valid,
    input  logic [7:0]            eng_r1,
    input  logic                  eng_data_valid,
    input  logic [7:0]            eng_data,
    input  logic                  eng_data_last,
    output logic                  eng_abort,
    output logic [2:0]            state_dbg
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_WAIT_R1 = 3'd2,
        S_DATA    = 3'd3,
        S_RETRY   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [9:0]    byte_cnt;
    logic [RW-1:0] retry_cnt;
    logic          failed;

    logic [NUM_REQ-1:0] win_oh;
    logic               win_found;
    logic [31:0]        win_sector;
    logic               addr_ovf;
    logic               is_last_byte;
    logic               timed_out;

`ifdef SD_SCHED_RR_EN
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win_idx;
    int            pick;
`endif

    assign state_dbg = state;

    // Search order k=0..NUM_REQ-1; round-robin rotates the order to start at rr_ptr.
    always_comb begin
        win_oh     = '0;
        win_found  = 1'b0;
        win_sector = '0;
`ifdef SD_SCHED_RR_EN
        win_idx = '0;
        pick    = 0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef SD_SCHED_RR_EN
            pick = int'(rr_ptr) + k;
            if (pick >= NUM_REQ) pick = pick - NUM_REQ;
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SD_SCHED_RR_EN
                if (!win_found && req_valid[i] && (i == pick)) begin
                    win_idx = IW'(i);
`else
                if (!win_found && req_valid[i] && (i == k)) begin
`endif
                    win_found  = 1'b1;
                    win_oh[i]  = 1'b1;
                    win_sector = req_sector[32*i +: 32];
                end
            end
        end
    end

    // SDSC byte address is sector*512; sectors at or above 2^23 do not fit in 32 bits.
    assign addr_ovf     = sdsc && (win_sector[31:23] != 9'd0);
    assign is_last_byte = (byte_cnt == 10'd511);
    assign timed_out    = (timer == TW'(TIMEOUT_CYC - 1));

    // Command handshake: a command transfers on a cycle with eng_cmd_valid=1 and
    // eng_cmd_ready=1; valid and arg stay stable until then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            timer         <= '0;
            byte_cnt      <= '0;
            retry_cnt     <= '0;
            failed        <= 1'b0;
            req_grant     <= '0;
            req_done      <= '0;
            req_error     <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            rd_last       <= 1'b0;
            eng_cmd_valid <= 1'b0;
            eng_cmd_index <= '0;
            eng_cmd_arg   <= '0;
            eng_abort     <= 1'b0;
`ifdef SD_SCHED_RR_EN
            rr_ptr        <= '0;
`endif
        end else begin
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            eng_abort <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (init_done && win_found) begin
                        req_grant   <= win_oh;
                        eng_cmd_arg <= sdsc ? {win_sector[22:0], 9'b0} : win_sector;
                        retry_cnt   <= '0;
                        failed      <= addr_ovf;
                        state       <= addr_ovf ? S_DONE : S_ISSUE;
`ifdef SD_SCHED_RR_EN
                        rr_ptr <= (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
                    end
                end
                S_ISSUE: begin
                    if (!eng_cmd_valid) begin
                        eng_cmd_valid <= 1'b1;
                        eng_cmd_index <= 6'd17;
                    end else if (eng_cmd_ready) begin
                        eng_cmd_valid <= 1'b0;
                        eng_cmd_index <= '0;
                        timer         <= '0;
                        state         <= S_WAIT_R1;
                    end
                end
                S_WAIT_R1: begin
                    if (eng_r1_valid) begin
                        if (eng_r1 == 8'h00) begin
                            timer    <= '0;
                            byte_cnt <= '0;
                            state    <= S_DATA;
                        end else begin
                            eng_abort <= 1'b1;
                            state     <= S_RETRY;
                        end
                    end else if (timed_out) begin
                        eng_abort <= 1'b1;
                        state     <= S_RETRY;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_DATA: begin
                    if (eng_data_valid) begin
                        // The engine's end marker must coincide exactly with byte 511.
                        if (eng_data_last != is_last_byte) begin
                            eng_abort <= 1'b1;
                            state     <= S_RETRY;
                        end else begin
                            rd_valid <= 1'b1;
                            rd_data  <= eng_data;
                            rd_last  <= is_last_byte;
                            byte_cnt <= byte_cnt + 1'b1;
                            if (is_last_byte) begin
                                failed <= 1'b0;
                                state  <= S_DONE;
                            end
                        end
                    end else if (byte_cnt == 10'd0) begin
                        if (timed_out) begin
                            eng_abort <= 1'b1;
                            state     <= S_RETRY;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
                S_RETRY: begin
                    retry_cnt <= retry_cnt + 1'b1;
                    if (retry_cnt < RW'(MAX_RETRY)) begin
                        state <= S_ISSUE;
                    end else begin
                        failed <= 1'b1;
                        state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    // First cycle raises the pulses, second cycle drops them with the grant.
                    if (req_done == '0) begin
                        req_done  <= req_grant;
                        req_error <= failed ? req_grant : '0;
                    end else begin
                        req_done  <= '0;
                        req_error <= '0;
                        req_grant <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
